// File: rtl/cell_pos_reader_if.sv
// Control, memory-port and particle-stream signals shared between the cell
// position reader (master) and its memory/consumer side (slave).
interface cell_pos_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] particle_count;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] out_pos;
    logic [ADDR_WIDTH-1:0] out_pid;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  start, mem_q, out_ready,
        output busy, done, particle_count, mem_addr, mem_rden, mem_wren,
               out_pos, out_pid, out_valid, out_last
    );

    modport slave (
        output start, mem_q, out_ready,
        input  busy, done, particle_count, mem_addr, mem_rden, mem_wren,
               out_pos, out_pid, out_valid, out_last
    );
endinterface

// File: rtl/cell_pos_reader.sv
// Reads the particle count from address 0 of a cell position memory, then
// streams every particle word out through a small credit-controlled FIFO.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    cell_pos_reader_if.master  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [ADDR_WIDTH-1:0] MAX_PID = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, FINISH} state_t;

    state_t                state_reg;
    logic                  busy_reg, done_reg, mem_rden_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, next_addr_reg, particle_count_reg;

    // Return tracker: each read is tagged with its address and lands two cycles later.
    logic                  ret0_valid_reg, ret1_valid_reg;
    logic [ADDR_WIDTH-1:0] ret0_tag_reg, ret1_tag_reg;

    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      fifo_count_reg;
    logic [DATA_WIDTH-1:0] entry_pos [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] entry_pid [FIFO_DEPTH];

    logic                  fifo_push, fifo_pop, out_valid, out_last, credit_ok;
    logic [SUM_W-1:0]      credit_sum;
    logic [ADDR_WIDTH-1:0] count_raw, count_clamped;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign count_raw     = bus.mem_q[ADDR_WIDTH-1:0];
    assign count_clamped = (count_raw > MAX_PID) ? MAX_PID : count_raw;

    assign fifo_push = ret1_valid_reg && (ret1_tag_reg != '0);
    assign out_valid = (fifo_count_reg != '0);
    assign out_last  = out_valid && (entry_pid[rd_ptr_reg] == particle_count_reg);
    assign fifo_pop  = out_valid && bus.out_ready;

    // Everything already committed (FIFO after this edge plus reads still in
    // the pipe) must leave room for one more read, so the FIFO cannot overflow.
    always_comb begin
        credit_sum = SUM_W'(fifo_count_reg) + SUM_W'(fifo_push) + SUM_W'(mem_rden_reg)
                   + SUM_W'(ret0_valid_reg) - SUM_W'(fifo_pop);
        credit_ok  = (credit_sum < SUM_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret0_valid_reg <= 1'b0;
            ret1_valid_reg <= 1'b0;
            ret0_tag_reg   <= '0;
            ret1_tag_reg   <= '0;
        end else begin
            ret0_valid_reg <= mem_rden_reg;
            ret0_tag_reg   <= mem_addr_reg;
            ret1_valid_reg <= ret0_valid_reg;
            ret1_tag_reg   <= ret0_tag_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] pos_reg;
            logic [ADDR_WIDTH-1:0] pid_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pos_reg <= '0;
                    pid_reg <= '0;
                end else if (fifo_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    pos_reg <= bus.mem_q;
                    pid_reg <= ret1_tag_reg;
                end
            end
            assign entry_pos[gi] = pos_reg;
            assign entry_pid[gi] = pid_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (fifo_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            mem_rden_reg       <= 1'b0;
            mem_addr_reg       <= '0;
            next_addr_reg      <= '0;
            particle_count_reg <= '0;
        end else begin
            done_reg     <= 1'b0;
            mem_rden_reg <= 1'b0;
            case (state_reg)
                IDLE: if (bus.start) begin
                    state_reg          <= CNT_REQ;
                    busy_reg           <= 1'b1;
                    mem_rden_reg       <= 1'b1;
                    mem_addr_reg       <= '0;
                    particle_count_reg <= '0;
                end
                CNT_REQ: state_reg <= CNT_WAIT;
                CNT_WAIT: if (ret1_valid_reg) begin
                    particle_count_reg <= count_clamped;
                    if (count_clamped == '0) begin
                        state_reg <= FINISH;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        mem_rden_reg  <= 1'b1;
                        mem_addr_reg  <= ADDR_WIDTH'(1);
                        next_addr_reg <= ADDR_WIDTH'(2);
                        state_reg     <= (count_clamped == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                    end
                end
                STREAM: if (credit_ok) begin
                    mem_rden_reg  <= 1'b1;
                    mem_addr_reg  <= next_addr_reg;
                    next_addr_reg <= next_addr_reg + ADDR_WIDTH'(1);
                    if (next_addr_reg == particle_count_reg) state_reg <= DRAIN;
                end
                // Beats leave in address order, so accepting the last one empties everything.
                DRAIN: if (fifo_pop && out_last && !mem_rden_reg && !ret0_valid_reg && !ret1_valid_reg) begin
                    state_reg <= FINISH;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                FINISH:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
    assign bus.particle_count = particle_count_reg;
    assign bus.mem_addr       = mem_addr_reg;
    assign bus.mem_rden       = mem_rden_reg;
    assign bus.mem_wren       = 1'b0;
    assign bus.out_pos        = entry_pos[rd_ptr_reg];
    assign bus.out_pid        = entry_pid[rd_ptr_reg];
    assign bus.out_valid      = out_valid;
    assign bus.out_last       = out_last;
endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: memory model with 2-cycle latency, expected-beat
// queue derived from the memory contents, table-driven and random runs.
module tb_cell_pos_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    cell_pos_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] q_stage;
    always @(posedge clk) begin
        q_stage   <= bus.mem_rden ? mem[bus.mem_addr] : '0;
        bus.mem_q <= q_stage;
    end

    typedef struct { logic [DW-1:0] pos; logic [AW-1:0] pid; } beat_t;
    typedef struct { logic [DW-1:0] cw; int mode; int restart_at; int exp_pcount; int exp_done; } vec_t;

    beat_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0;
    bit mon_en = 1'b0;
    int issued, accepted, addr0_reads, exp_rd_addr, done_cnt, done_cyc, first_valid_cyc, eff_count;
    bit prev_stall;
    logic [DW+AW:0] prev_snap;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int model_eff(input logic [DW-1:0] cw);
        int c;
        c = int'(cw[AW-1:0]);
        return (c > PN - 1) ? PN - 1 : c;
    endfunction

    function automatic logic ready_val(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},   bus.busy, 0);
        check({tag, "_done"},   bus.done, 0);
        check({tag, "_rden"},   bus.mem_rden, 0);
        check({tag, "_wren"},   bus.mem_wren, 0);
        check({tag, "_valid"},  {bus.out_valid, bus.out_last}, 0);
        check({tag, "_addr"},   bus.mem_addr, 0);
        check({tag, "_pid"},    bus.out_pid, 0);
        check({tag, "_pos"},    bus.out_pos, 0);
        check({tag, "_pcount"}, bus.particle_count, 0);
    endtask

    // Continuous monitor: ordering, credit bound, stall stability, done pulses.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall)
                    check("stall_hold", {bus.out_pos, bus.out_pid, bus.out_last}, prev_snap);
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_snap  = {bus.out_pos, bus.out_pid, bus.out_last};
                check("wren_zero", bus.mem_wren, 0);
                if (bus.mem_rden) begin
                    if (bus.mem_addr == '0) addr0_reads++;
                    else begin
                        check("rd_addr", bus.mem_addr, exp_rd_addr);
                        exp_rd_addr++;
                        issued++;
                        check("credit_ok", (issued - accepted) <= FD, 1);
                    end
                end
                if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_beat", bus.out_pid, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("beat", {bus.out_pos, bus.out_pid, bus.out_last},
                              {e.pos, e.pid, (int'(e.pid) == eff_count)});
                    end
                    accepted++;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_at_done", bus.busy, 0);
                end
            end
        end
    end

    task automatic run_cell(input logic [DW-1:0] cw, input int mode, input int restart_at,
                            input int exp_pcount, input int exp_done, input bit fill, input string tag);
        beat_t b;
        mem[0] = cw;
        if (fill) for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
        eff_count = model_eff(cw);
        exp_q.delete();
        for (int i = 1; i <= eff_count; i++) begin
            b.pos = mem[i];
            b.pid = AW'(i);
            exp_q.push_back(b);
        end
        issued = 0; accepted = 0; addr0_reads = 0; exp_rd_addr = 1;
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; prev_stall = 1'b0;
        cyc = 0;
        mon_en = 1'b1;
        bus.start = 1'b1;
        bus.out_ready = ready_val(mode, cyc);
        tick();
        bus.start = 1'b0;
        check({tag, "_c1_busy_rden_addr"}, {bus.busy, bus.mem_rden, bus.mem_addr}, {2'b11, 8'd0});
        while (done_cnt == 0 && cyc < 2000) begin
            bus.start = (cyc == restart_at);
            bus.out_ready = ready_val(mode, cyc);
            tick();
        end
        bus.start = 1'b0;
        repeat (4) begin
            bus.out_ready = ready_val(mode, cyc);
            tick();
        end
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_beats_left"}, exp_q.size(), 0);
        check({tag, "_pcount"}, bus.particle_count, exp_pcount);
        check({tag, "_reads"}, issued, eff_count);
        check({tag, "_addr0_reads"}, addr0_reads, 1);
        if (exp_done >= 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
        if (mode == 0 && eff_count > 0) check({tag, "_first_valid"}, first_valid_cyc, 7);
        $display("[TB] run %s: count word %0d -> %0d beats, done cycle %0d", tag, cw[AW-1:0], accepted, done_cyc);
    endtask

    vec_t vecs[8];
    logic [DW-1:0] cw;

    initial begin
        vecs[0] = '{96'd3,                 0, -1,   3,  10};
        vecs[1] = '{96'd0,                 0, -1,   0,   4};
        vecs[2] = '{96'd10,                1, -1,  10,  -1};
        vecs[3] = '{96'd5,                 0,  5,   5,  12};
        vecs[4] = '{96'd1,                 0, -1,   1,   8};
        vecs[5] = '{96'd250,               0, -1, 219, 226};
        vecs[6] = '{96'd220,               0, -1, 219, 226};
        vecs[7] = '{{88'hA5A5_1234, 8'd2}, 0, -1,   2,   9};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check_reset_values("por");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++)
            run_cell(vecs[v].cw, vecs[v].mode, vecs[v].restart_at, vecs[v].exp_pcount,
                     vecs[v].exp_done, 1'b1, $sformatf("vec%0d", v));

        // Abort a count-8 read mid-stream, then rerun on the same memory.
        mon_en = 1'b0;
        mem[0] = 96'd8;
        for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
        cyc = 0;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < 8) tick();
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("midrst_no_stale", {bus.out_valid, bus.done, bus.busy}, 0);
        end
        run_cell(96'd8, 0, -1, 8, 15, 1'b0, "after_rst");

        for (int r = 0; r < 8; r++) begin
            cw = {$urandom, $urandom, $urandom};
            cw[AW-1:0] = (r == 7) ? AW'($urandom_range(221, 255)) : AW'($urandom_range(0, 40));
            run_cell(cw, 2, -1, model_eff(cw), -1, 1'b1, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
